// File: rtl/stepper_move_ctrl.sv
// Half-step move sequencer for a 4-wire stepper: accepts counted moves, steps the
// coil pattern at a fixed rate, tracks absolute position and releases coils when idle.
module stepper_move_ctrl #(
    parameter int CLK_HZ      = 50000000,
    parameter int MIN_PERIOD  = 1000,
    parameter int HOLD_CYCLES = 5000000
) (
    input  logic        CLK50MHZ,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_steps,
    input  logic        cmd_dir,
    input  logic [23:0] cmd_period,
    input  logic        abort,
    output logic [3:0]  coils,
    output logic        step_tick,
    output logic        busy,
    output logic        done,
    output logic        aborted,
    output logic [31:0] position,
    output logic [15:0] steps_left
);

    localparam logic [23:0] MIN_P     = 24'(MIN_PERIOD);
    localparam logic [31:0] HOLD_LAST = (HOLD_CYCLES > 0) ? 32'(HOLD_CYCLES - 1) : 32'd0;

    // A zero minimum period would make the rate counter compare wrap.
    if (MIN_PERIOD < 1 || CLK_HZ < 1) begin : g_param_check
        $error("stepper_move_ctrl: MIN_PERIOD and CLK_HZ must be positive");
    end

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q;
    logic [2:0]  phase_q;
    logic        dir_q;
    logic [23:0] period_q;
    logic [23:0] rate_q;
    logic [31:0] hold_q;
    logic        pend_abort_q;
    logic [3:0]  coils_q;
    logic        cmd_ready_q;
    logic        step_tick_q;
    logic        busy_q;
    logic        done_q;
    logic        aborted_q;
    logic [31:0] position_q;
    logic [15:0] steps_left_q;

    logic [23:0] eff_period_d;
    logic [2:0]  phase_d;
    logic        step_now;

    function automatic logic [3:0] phase_coils(input logic [2:0] idx);
        logic [3:0] pat;
        case (idx)
            3'd0:    pat = 4'b0100;
            3'd1:    pat = 4'b0101;
            3'd2:    pat = 4'b0001;
            3'd3:    pat = 4'b1001;
            3'd4:    pat = 4'b1000;
            3'd5:    pat = 4'b1010;
            3'd6:    pat = 4'b0010;
            default: pat = 4'b0110;
        endcase
        return pat;
    endfunction

    always_comb begin
        eff_period_d = (cmd_period < MIN_P) ? MIN_P : cmd_period;
        phase_d      = dir_q ? (phase_q + 3'd1) : (phase_q - 3'd1);
        step_now     = (rate_q == (period_q - 24'd1)) && (steps_left_q != 16'd0);
    end

    always_ff @(posedge CLK50MHZ) begin
        if (reset) begin
            state_q      <= IDLE;
            phase_q      <= 3'd0;
            dir_q        <= 1'b0;
            period_q     <= MIN_P;
            rate_q       <= 24'd0;
            hold_q       <= 32'd0;
            pend_abort_q <= 1'b0;
            coils_q      <= 4'b0000;
            cmd_ready_q  <= 1'b1;
            step_tick_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            position_q   <= 32'd0;
            steps_left_q <= 16'd0;
        end else begin
            step_tick_q <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        coils_q      <= phase_coils(phase_q);
                        hold_q       <= 32'd0;
                        period_q     <= eff_period_d;
                        dir_q        <= cmd_dir;
                        steps_left_q <= cmd_steps;
                        rate_q       <= 24'd0;
                        pend_abort_q <= 1'b0;
                        if (cmd_steps == 16'd0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q     <= RUN;
                            busy_q      <= 1'b1;
                            cmd_ready_q <= 1'b0;
                        end
                    end else if (HOLD_CYCLES > 0 && coils_q != 4'b0000) begin
                        hold_q <= hold_q + 32'd1;
                        if (hold_q == HOLD_LAST) begin
                            coils_q <= 4'b0000;
                        end
                    end
                end
                RUN: begin
                    rate_q <= rate_q + 24'd1;
                    // Move ends the cycle after its last step, or after a step that coincided with abort.
                    if (steps_left_q == 16'd0 || pend_abort_q) begin
                        state_q     <= IDLE;
                        busy_q      <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        done_q      <= 1'b1;
                        aborted_q   <= pend_abort_q | abort;
                        hold_q      <= 32'd0;
                    end else if (step_now) begin
                        rate_q       <= 24'd0;
                        phase_q      <= phase_d;
                        coils_q      <= phase_coils(phase_d);
                        position_q   <= dir_q ? (position_q + 32'd1) : (position_q - 32'd1);
                        steps_left_q <= steps_left_q - 16'd1;
                        step_tick_q  <= 1'b1;
                        if (abort) begin
                            pend_abort_q <= 1'b1;
                        end
                    end else if (abort) begin
                        state_q     <= IDLE;
                        busy_q      <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        done_q      <= 1'b1;
                        aborted_q   <= 1'b1;
                        hold_q      <= 32'd0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign coils      = coils_q;
    assign step_tick  = step_tick_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign aborted    = aborted_q;
    assign position   = position_q;
    assign steps_left = steps_left_q;

endmodule

// File: tb/tb_stepper_move_ctrl.sv
// Bench for stepper_move_ctrl: a move-level reference model checked every cycle,
// plus directed moves with hand-computed coil patterns, positions and timings.
module tb_stepper_move_ctrl;

    localparam int MINP = 1000;
    localparam int HOLD = 100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [15:0] cmd_steps = 16'd0;
    logic        cmd_dir = 1'b0;
    logic [23:0] cmd_period = 24'd0;
    logic        abort = 1'b0;
    logic        cmd_ready;
    logic [3:0]  coils;
    logic        step_tick;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [31:0] position;
    logic [15:0] steps_left;

    always #5 clk = ~clk;

    stepper_move_ctrl #(
        .CLK_HZ     (50000000),
        .MIN_PERIOD (MINP),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .CLK50MHZ  (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_steps (cmd_steps),
        .cmd_dir   (cmd_dir),
        .cmd_period(cmd_period),
        .abort     (abort),
        .coils     (coils),
        .step_tick (step_tick),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .position  (position),
        .steps_left(steps_left)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, req, $time);
        end
    endtask

    // Reference model: a move is described by its accept cycle, period and count;
    // a step is due whenever the elapsed time is a whole multiple of the period.
    logic [3:0]  ptab [8] = '{4'b0100, 4'b0101, 4'b0001, 4'b1001,
                              4'b1000, 4'b1010, 4'b0010, 4'b0110};
    int          cyc = 0;
    bit          model_ok = 1'b0;
    bit          m_run = 1'b0, energized = 1'b0, end_next = 1'b0, end_abt = 1'b0, m_dir = 1'b0;
    int          m_start, m_p, m_n, m_k, idle_start, cur_phase;
    logic [31:0] cur_pos;
    logic [3:0]  exp_coils;
    logic [15:0] exp_left;
    logic        exp_tick, exp_done, exp_abt, exp_busy, exp_ready;

    task automatic model_finish(input bit a);
        m_run      = 1'b0;
        exp_done   = 1'b1;
        exp_abt    = a;
        idle_start = cyc;
    endtask

    always @(posedge clk) begin
        cyc++;
        exp_tick = 1'b0;
        exp_done = 1'b0;
        exp_abt  = 1'b0;
        if (reset) begin
            model_ok  = 1'b1;
            m_run     = 1'b0;
            energized = 1'b0;
            end_next  = 1'b0;
            end_abt   = 1'b0;
            cur_phase = 0;
            cur_pos   = 32'd0;
            exp_left  = 16'd0;
        end else if (!m_run) begin
            if (cmd_valid) begin
                energized  = 1'b1;
                idle_start = cyc;
                m_p        = (int'(cmd_period) < MINP) ? MINP : int'(cmd_period);
                exp_left   = cmd_steps;
                if (cmd_steps == 16'd0) begin
                    exp_done = 1'b1;
                end else begin
                    m_run    = 1'b1;
                    m_start  = cyc;
                    m_n      = int'(cmd_steps);
                    m_dir    = cmd_dir;
                    m_k      = 0;
                    end_next = 1'b0;
                    end_abt  = 1'b0;
                end
            end else if (energized && (cyc - idle_start) >= HOLD) begin
                energized = 1'b0;
            end
        end else begin
            if (end_next) begin
                model_finish(end_abt || abort);
            end else if (((cyc - m_start) % m_p) == 0) begin
                m_k++;
                cur_phase = (cur_phase + (m_dir ? 1 : 7)) % 8;
                cur_pos   = m_dir ? cur_pos + 32'd1 : cur_pos - 32'd1;
                exp_left  = 16'(m_n - m_k);
                exp_tick  = 1'b1;
                if (abort) begin
                    end_next = 1'b1;
                    end_abt  = 1'b1;
                end else if (m_k == m_n) begin
                    end_next = 1'b1;
                end
            end else if (abort) begin
                model_finish(1'b1);
            end
        end
        exp_busy  = m_run;
        exp_ready = !m_run;
        exp_coils = energized ? ptab[cur_phase] : 4'b0000;
    end

    always @(negedge clk) begin
        if (model_ok) begin
            check("m_coils", coils, exp_coils);
            check("m_tick", step_tick, exp_tick);
            check("m_done", done, exp_done);
            check("m_aborted", aborted, exp_abt);
            check("m_busy", busy, exp_busy);
            check("m_ready", cmd_ready, exp_ready);
            check("m_position", position, cur_pos);
            check("m_steps_left", steps_left, exp_left);
        end
    end

    task automatic issue(input int steps, input bit dir, input int period);
        $display("cmd steps=%0d dir=%0d period=%0d t=%0t", steps, dir, period, $time);
        cmd_valid  = 1'b1;
        cmd_steps  = 16'(steps);
        cmd_dir    = dir;
        cmd_period = 24'(period);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic step_check(input int p, input logic [3:0] want, input string name);
        repeat (p - 1) @(negedge clk);
        check({name, "_pre_tick"}, step_tick, 1'b0);
        @(negedge clk);
        check({name, "_tick"}, step_tick, 1'b1);
        check({name, "_coils"}, coils, want);
    endtask

    task automatic wait_done(input int limit, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check({name, "_done_seen"}, seen, 1'b1);
    endtask

    initial begin
        logic [3:0] fwd_seq [8];
        logic [3:0] rev_seq [3];
        logic [3:0] ret_seq [3];
        fwd_seq = '{4'b0101, 4'b0001, 4'b1001, 4'b1000, 4'b1010, 4'b0010, 4'b0110, 4'b0100};
        rev_seq = '{4'b0110, 4'b0010, 4'b1010};
        ret_seq = '{4'b0010, 4'b0110, 4'b0100};

        repeat (3) @(negedge clk);
        check("rst_coils", coils, 4'b0000);
        check("rst_ready", cmd_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_position", position, 32'd0);
        check("rst_steps_left", steps_left, 16'd0);
        reset = 1'b0;

        issue(8, 1'b1, 1000);
        check("t1_busy", busy, 1'b1);
        check("t1_ready", cmd_ready, 1'b0);
        check("t1_left", steps_left, 16'd8);
        check("t1_coils0", coils, 4'b0100);
        for (int k = 0; k < 8; k++) step_check(1000, fwd_seq[k], "t1_step");
        check("t1_pos", position, 32'd8);
        @(negedge clk);
        check("t1_done", done, 1'b1);
        check("t1_aborted", aborted, 1'b0);
        check("t1_busy_end", busy, 1'b0);

        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        issue(3, 1'b0, 1000);
        for (int k = 0; k < 3; k++) step_check(1000, rev_seq[k], "t2_rev");
        check("t2_pos_neg", position, 32'hFFFF_FFFD);
        @(negedge clk);
        check("t2_done", done, 1'b1);
        issue(3, 1'b1, 1000);
        for (int k = 0; k < 3; k++) step_check(1000, ret_seq[k], "t2_fwd");
        check("t2_pos_zero", position, 32'd0);
        @(negedge clk);
        check("t2_done2", done, 1'b1);

        issue(2, 1'b1, 5);
        repeat (999) @(negedge clk);
        check("t3_no_early_tick", step_tick, 1'b0);
        check("t3_left_pre", steps_left, 16'd2);
        @(negedge clk);
        check("t3_tick1", step_tick, 1'b1);
        check("t3_left1", steps_left, 16'd1);
        step_check(1000, 4'b0001, "t3_step2");
        check("t3_pos", position, 32'd2);
        wait_done(5, "t3");

        issue(0, 1'b1, 1000);
        check("t4_done", done, 1'b1);
        check("t4_aborted", aborted, 1'b0);
        check("t4_tick", step_tick, 1'b0);
        check("t4_coils", coils, 4'b0001);
        check("t4_pos", position, 32'd2);

        issue(10, 1'b1, 1000);
        repeat (2499) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t5_done", done, 1'b1);
        check("t5_aborted", aborted, 1'b1);
        check("t5_left", steps_left, 16'd8);
        check("t5_pos", position, 32'd4);
        check("t5_busy", busy, 1'b0);

        issue(10, 1'b0, 1000);
        repeat (2999) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t6_tick", step_tick, 1'b1);
        check("t6_left", steps_left, 16'd7);
        @(negedge clk);
        check("t6_done", done, 1'b1);
        check("t6_aborted", aborted, 1'b1);
        check("t6_pos", position, 32'd1);
        check("t6_coils", coils, 4'b0101);

        repeat (99) @(negedge clk);
        check("t7_held", coils, 4'b0101);
        @(negedge clk);
        check("t7_released", coils, 4'b0000);
        repeat (10) @(negedge clk);
        issue(1, 1'b1, 1000);
        check("t7_reenergize", coils, 4'b0101);
        step_check(1000, 4'b0001, "t7_step");
        check("t7_pos", position, 32'd2);
        @(negedge clk);
        check("t7_done", done, 1'b1);

        $display("cmd steps=5 dir=1 period=1000 held-valid t=%0t", $time);
        cmd_valid  = 1'b1;
        cmd_steps  = 16'd5;
        cmd_dir    = 1'b1;
        cmd_period = 24'd1000;
        @(negedge clk);
        cmd_steps = 16'd9;
        check("t8_ready", cmd_ready, 1'b0);
        check("t8_left", steps_left, 16'd5);
        repeat (1000) @(negedge clk);
        check("t8_left_step", steps_left, 16'd4);
        check("t8_coils", coils, 4'b1001);
        repeat (500) @(negedge clk);
        cmd_valid = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t8_rst_coils", coils, 4'b0000);
        check("t8_rst_busy", busy, 1'b0);
        check("t8_rst_ready", cmd_ready, 1'b1);
        check("t8_rst_done", done, 1'b0);
        check("t8_rst_pos", position, 32'd0);
        check("t8_rst_left", steps_left, 16'd0);
        repeat (20) @(negedge clk);
        check("t8_no_late_done", done, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
